// File: rtl/id_pkg.sv
// Shared types and constants for the ID-stage register scoreboard.
package id_pkg;

   localparam logic [4:0]  REG_ZERO       = 5'd0;
   localparam int unsigned NUM_STAGES_DEF = 5;
   // Stored destination width; must be >= the scoreboard's ADDR_W.
   localparam int unsigned ENTRY_RD_W     = 8;

   typedef struct packed {
      logic                  valid;
      logic [ENTRY_RD_W-1:0] rd;
   } entry_t;

endpackage

// File: rtl/id_scoreboard_entry_match.sv
// Compares one in-flight entry against the ID-stage source registers.
module id_scoreboard_entry_match
   import id_pkg::*;
#(
   parameter int unsigned RD_W = 8
) (
   input  logic            valid,
   input  logic [RD_W-1:0] rd,
   input  logic [RD_W-1:0] rs,
   input  logic [RD_W-1:0] rt,
   input  logic            uses_rs,
   input  logic            uses_rt,
   output logic            hit
);

   logic rd_nonzero;

   assign rd_nonzero = (rd != RD_W'(REG_ZERO));
   assign hit = valid && rd_nonzero && ((uses_rs && (rd == rs)) || (uses_rt && (rd == rt)));

endmodule

// File: rtl/id_scoreboard_p.sv
// Register scoreboard for the ID stage: tracks in-flight destinations, stalls on RAW hazards.
module id_scoreboard_p
   import id_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
   parameter int unsigned ADDR_W     = 5,
   parameter bit          WB_BYPASS  = 1'b1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   IssueValid,
   input  logic [ADDR_W-1:0]      Rs,
   input  logic [ADDR_W-1:0]      Rt,
   input  logic                   UsesRs,
   input  logic                   UsesRt,
   input  logic                   IssueRegWrite,
   input  logic [ADDR_W-1:0]      IssueRd,
   input  logic                   BranchTaken,
   input  logic                   Freeze,
   output logic                   oPCWrite,
   output logic                   oIFIDWrite,
   output logic                   oIDEXFlush,
   output logic                   oIFIDFlush,
   output logic [2**ADDR_W-1:0]   oPending,
   output logic [CNT_W-1:0]       oStallCount
);

   localparam int unsigned NUM_REGS    = 2**ADDR_W;
   localparam int unsigned NUM_CHECKED = WB_BYPASS ? NUM_STAGES - 1 : NUM_STAGES;

   entry_t                entry_q [NUM_STAGES];
   entry_t                entry_d [NUM_STAGES];
   logic [NUM_STAGES-1:0] hit;
   logic                  hazard;
   logic                  stall;
   logic [NUM_REGS-1:0]   pending_q;
   logic [NUM_REGS-1:0]   pending_d;
   logic [CNT_W-1:0]      count_q;

   for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_match
      // With write-before-read, the final stage is already visible to the reader.
      localparam bit Checked = (k < int'(NUM_CHECKED));

      id_scoreboard_entry_match #(
         .RD_W (ENTRY_RD_W)
      ) u_match (
         .valid   (entry_q[k].valid & Checked),
         .rd      (entry_q[k].rd),
         .rs      (ENTRY_RD_W'(Rs)),
         .rt      (ENTRY_RD_W'(Rt)),
         .uses_rs (UsesRs),
         .uses_rt (UsesRt),
         .hit     (hit[k])
      );
   end

   assign hazard      = IssueValid && (|hit);
   assign stall       = hazard && !Freeze;
   assign oPCWrite    = !(hazard || Freeze);
   assign oIFIDWrite  = !(hazard || Freeze);
   assign oIDEXFlush  = stall;
   assign oIFIDFlush  = BranchTaken && !hazard && !Freeze;
   assign oPending    = pending_q;
   assign oStallCount = count_q;

   always_comb begin
      entry_d = entry_q;
      if (!Freeze) begin
         for (int k = 1; k < int'(NUM_STAGES); k++) begin
            entry_d[k] = entry_q[k-1];
         end
         entry_d[0].valid = IssueValid && IssueRegWrite && !stall &&
                            (IssueRd != ADDR_W'(REG_ZERO));
         entry_d[0].rd    = ENTRY_RD_W'(IssueRd);
      end
   end

   // Decode from the next-state entries so oPending lines up with entry_q.
   always_comb begin
      pending_d = '0;
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
         if (entry_d[k].valid) begin
            pending_d[entry_d[k].rd[ADDR_W-1:0]] = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 0; k < int'(NUM_STAGES); k++) begin
            entry_q[k] <= '0;
         end
         pending_q <= '0;
         count_q   <= '0;
      end else if (!Freeze) begin
         entry_q   <= entry_d;
         pending_q <= pending_d;
         if (stall && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_id_scoreboard_p.sv
// Bench for id_scoreboard_p: directed vector table, corner sequences, random vs. age model.
module tb_id_scoreboard_p;

   localparam int N    = 5;
   localparam int NCHK = 4;
   localparam int BIG  = 1000;

   logic        Clk;
   logic        Reset;
   logic        IssueValid;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic        UsesRs;
   logic        UsesRt;
   logic        IssueRegWrite;
   logic [4:0]  IssueRd;
   logic        BranchTaken;
   logic        Freeze;

   logic        pc_write;
   logic        ifid_write;
   logic        idex_flush;
   logic        ifid_flush;
   logic [31:0] pending;
   logic [31:0] stall_count;

   logic        s_pc_write;
   logic        s_ifid_write;
   logic        s_idex_flush;
   logic        s_ifid_flush;
   logic [31:0] s_pending;
   logic [2:0]  s_stall_count;

   id_scoreboard_p dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .IssueValid    (IssueValid),
      .Rs            (Rs),
      .Rt            (Rt),
      .UsesRs        (UsesRs),
      .UsesRt        (UsesRt),
      .IssueRegWrite (IssueRegWrite),
      .IssueRd       (IssueRd),
      .BranchTaken   (BranchTaken),
      .Freeze        (Freeze),
      .oPCWrite      (pc_write),
      .oIFIDWrite    (ifid_write),
      .oIDEXFlush    (idex_flush),
      .oIFIDFlush    (ifid_flush),
      .oPending      (pending),
      .oStallCount   (stall_count)
   );

   id_scoreboard_p #(
      .CNT_W (3)
   ) dut_sat (
      .Clk           (Clk),
      .Reset         (Reset),
      .IssueValid    (IssueValid),
      .Rs            (Rs),
      .Rt            (Rt),
      .UsesRs        (UsesRs),
      .UsesRt        (UsesRt),
      .IssueRegWrite (IssueRegWrite),
      .IssueRd       (IssueRd),
      .BranchTaken   (BranchTaken),
      .Freeze        (Freeze),
      .oPCWrite      (s_pc_write),
      .oIFIDWrite    (s_ifid_write),
      .oIDEXFlush    (s_idex_flush),
      .oIFIDFlush    (s_ifid_flush),
      .oPending      (s_pending),
      .oStallCount   (s_stall_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit          rst, iv, urs, urt, rw, br, frz;
      logic [4:0]  rs, rt, rd;
      bit          e_flush, e_pcw, e_iff;
      logic [31:0] e_pend;
      logic [31:0] e_cnt;
   } vec_t;

   // Model: age[r] = edges since the youngest in-flight write of r was issued.
   int     age [32];
   longint cnt;
   int     errors;
   int     checks;
   int     cyc;

   function automatic vec_t mk(bit rst, bit iv, int rs, bit urs, int rt, bit urt, bit rw,
                               int rd, bit br, bit frz, bit e_flush, bit e_pcw, bit e_iff,
                               int e_pend, int e_cnt);
      vec_t v;
      v.rst = rst; v.iv = iv; v.rs = 5'(rs); v.urs = urs; v.rt = 5'(rt); v.urt = urt;
      v.rw = rw; v.rd = 5'(rd); v.br = br; v.frz = frz;
      v.e_flush = e_flush; v.e_pcw = e_pcw; v.e_iff = e_iff;
      v.e_pend = 32'(e_pend); v.e_cnt = 32'(e_cnt);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit m_hazard();
      bit h;
      h = 1'b0;
      if (UsesRs && Rs != 0 && age[Rs] < NCHK) h = 1'b1;
      if (UsesRt && Rt != 0 && age[Rt] < NCHK) h = 1'b1;
      return IssueValid && h;
   endfunction

   function automatic logic [31:0] m_pending();
      logic [31:0] p;
      p = '0;
      for (int r = 1; r < 32; r++) if (age[r] < N) p[r] = 1'b1;
      return p;
   endfunction

   task automatic m_reset();
      for (int r = 0; r < 32; r++) age[r] = BIG;
      cnt = 0;
   endtask

   task automatic run_cycle(input vec_t v, input bit use_exp);
      bit     hz;
      bit     st;
      longint sat;
      Reset = v.rst; IssueValid = v.iv; Rs = v.rs; Rt = v.rt; UsesRs = v.urs;
      UsesRt = v.urt; IssueRegWrite = v.rw; IssueRd = v.rd; BranchTaken = v.br;
      Freeze = v.frz;
      @(negedge Clk);
      hz  = m_hazard();
      st  = hz && !Freeze;
      sat = (cnt > 7) ? 7 : cnt;
      chk("pc_write", 64'(pc_write), 64'(!(hz || Freeze)));
      chk("ifid_write", 64'(ifid_write), 64'(!(hz || Freeze)));
      chk("idex_flush", 64'(idex_flush), 64'(st));
      chk("ifid_flush", 64'(ifid_flush), 64'(BranchTaken && !hz && !Freeze));
      chk("pending", 64'(pending), 64'(m_pending()));
      chk("stall_count", 64'(stall_count), 64'(cnt));
      chk("sat_count", 64'(s_stall_count), 64'(sat));
      chk("sat_flush", 64'(s_idex_flush), 64'(st));
      if (use_exp) begin
         chk("tbl_flush", 64'(idex_flush), 64'(v.e_flush));
         chk("tbl_pcw", 64'(pc_write), 64'(v.e_pcw));
         chk("tbl_iff", 64'(ifid_flush), 64'(v.e_iff));
         chk("tbl_pend", 64'(pending), 64'(v.e_pend));
         chk("tbl_cnt", 64'(stall_count), 64'(v.e_cnt));
      end
      @(posedge Clk);
      if (v.rst) begin
         m_reset();
      end else if (!v.frz) begin
         for (int r = 0; r < 32; r++) if (age[r] < BIG) age[r]++;
         if (st) cnt++;
         if (v.iv && v.rw && !st && v.rd != 0) age[v.rd] = 0;
      end
      cyc++;
      #1;
   endtask

   vec_t tbl [24];
   vec_t rv;

   initial begin
      errors = 0; checks = 0; cyc = 0;
      Reset = 1'b1; IssueValid = 1'b0; Rs = '0; Rt = '0; UsesRs = 1'b0; UsesRt = 1'b0;
      IssueRegWrite = 1'b0; IssueRd = '0; BranchTaken = 1'b0; Freeze = 1'b0;
      m_reset();
      @(posedge Clk);
      @(posedge Clk);
      #1;

      //          rst iv rs us rt ut rw rd br fz  fl pcw iff pend    cnt
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0,  0,      0);
      tbl[1]  = mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 0,  0, 1,  0,  0,      0);
      tbl[2]  = mk(0, 1, 8, 1, 0, 0, 1, 9, 0, 0,  1, 0,  0,  'h100,  0);
      tbl[3]  = mk(0, 1, 8, 1, 0, 0, 1, 9, 0, 0,  1, 0,  0,  'h100,  1);
      tbl[4]  = mk(0, 1, 8, 1, 0, 0, 1, 9, 0, 0,  1, 0,  0,  'h100,  2);
      tbl[5]  = mk(0, 1, 8, 1, 0, 0, 1, 9, 0, 0,  1, 0,  0,  'h100,  3);
      tbl[6]  = mk(0, 1, 8, 1, 0, 0, 1, 9, 0, 0,  0, 1,  0,  'h100,  4);
      tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0,  'h200,  4);
      tbl[8]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 1,  0,  'h200,  4);
      tbl[9]  = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0,  0, 1,  0,  'h200,  4);
      tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0,  'h200,  4);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0,  'h200,  4);
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0,  0,      4);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1,  1,  0,      4);
      tbl[14] = mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0,  0, 1,  0,  0,      4);
      tbl[15] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 0,  1, 0,  0,  'h8,    4);
      tbl[16] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 0,  1, 0,  0,  'h8,    5);
      tbl[17] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 1,  0, 0,  0,  'h8,    6);
      tbl[18] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 1,  0, 0,  0,  'h8,    6);
      tbl[19] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 1,  0, 0,  0,  'h8,    6);
      tbl[20] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 0,  1, 0,  0,  'h8,    6);
      tbl[21] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 0,  1, 0,  0,  'h8,    7);
      tbl[22] = mk(0, 1, 3, 1, 0, 0, 0, 0, 1, 0,  0, 1,  1,  'h8,    8);
      tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1,  0,  0,      8);
      foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

      // Saturation: four more stalls push the 3-bit counter well past all-ones.
      run_cycle(mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      for (int i = 0; i < 5; i++) begin
         run_cycle(mk(0, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      end
      chk("sat_hold", 64'(s_stall_count), 64'd7);
      chk("cnt_after_sat", 64'(stall_count), 64'd12);

      // Reset with three writes of r5 in flight.
      for (int i = 0; i < 3; i++) begin
         run_cycle(mk(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      end
      run_cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h20, 12), 1'b1);
      run_cycle(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);

      // Reset while a stall is in progress.
      run_cycle(mk(0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 0, 0, 0), 1'b1);
      run_cycle(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h40, 0), 1'b1);
      run_cycle(mk(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h40, 1), 1'b1);
      run_cycle(mk(0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b1);

      for (int i = 0; i < 3000; i++) begin
         rv = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 0, 0, 0, 0, 0);
         run_cycle(rv, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_scoreboard_p.md
ID_SCOREBOARD_P -- requirements
Module: id_scoreboard_p

Interface
REQ-001 Parameter NUM_STAGES, default 5, number of in-flight stages tracked between ID and register-file write (EX, MEM, SAD1..SAD3).
REQ-002 Parameter ADDR_W, default 5, register-address width.
REQ-003 Parameter WB_BYPASS, default 1; 1 = register file writes before it reads, so the final stage never causes a hazard.
REQ-004 Parameter CNT_W, default 32, width of the stall counter.
REQ-005 Clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 IssueValid  input  1  the ID stage holds a real instruction.
REQ-008 Rs, Rt  input  ADDR_W each  source-register addresses (Instruction[25:21], [20:16]).
REQ-009 UsesRs, UsesRt  input  1 each  the instruction reads Rs / Rt.
REQ-010 IssueRegWrite  input  1  the instruction writes a register.
REQ-011 IssueRd  input  ADDR_W  final destination address after the RegDst select.
REQ-012 BranchTaken  input  1  the branch resolved in ID is taken this cycle.
REQ-013 Freeze  input  1  a cache miss is freezing the pipeline.
REQ-014 oPCWrite, oIFIDWrite  output  1 each  PC and IF/ID register write enables.
REQ-015 oIDEXFlush  output  1  insert a bubble into ID/EX.
REQ-016 oIFIDFlush  output  1  squash the fetched instruction.
REQ-017 oPending  output  2**ADDR_W  bit r = 1 when a valid in-flight entry targets register r.
REQ-018 oStallCount  output  CNT_W  number of hazard-stall cycles.

Function
REQ-019 State: NUM_STAGES entries {valid, rd}; entry 0 = EX, entry NUM_STAGES-1 = write-back.
REQ-020 Hazard is combinational: IssueValid and there is a valid entry k with rd != 0 and (UsesRs and rd == Rs, or UsesRt and rd == Rt).
REQ-021 When WB_BYPASS = 1, entry NUM_STAGES-1 is excluded from the hazard check.
REQ-022 A source address of 0 never causes a hazard.
REQ-023 Stall = Hazard and not Freeze.
REQ-024 oPCWrite = oIFIDWrite = not (Hazard or Freeze).
REQ-025 oIDEXFlush = Stall.
REQ-026 oIFIDFlush = BranchTaken and not Hazard and not Freeze.
REQ-027 A taken branch during a stall is ignored; the ID stage presents it again in the next cycle.
REQ-028 When Freeze = 1, no entry shifts and oStallCount holds, whatever the other inputs.
REQ-029 When Freeze = 0, entries shift (entry k-1 -> entry k) and the last entry retires.
REQ-030 Entry 0 loads valid = IssueValid and IssueRegWrite and not Stall and IssueRd != 0, with rd = IssueRd.
REQ-031 On a stall, entry 0 loads a bubble (valid = 0).
REQ-032 oPending is the registered OR of the decoded valid entries; it is updated in the same edge as the entries, so it has zero extra latency relative to them.
REQ-033 oStallCount increments by 1 on each edge where Stall = 1.
REQ-034 oStallCount saturates at all-ones and does not wrap.
REQ-035 Multiple matching entries give one stall per cycle; the stall releases the cycle after the last matching entry leaves the checked range.

Reset
REQ-036 When Reset = 1 at an edge, all entries become invalid and oStallCount becomes 0, so oPending = 0.
REQ-037 Reset has priority over Freeze and issue.
REQ-038 Reset asserted mid-stall releases the stall in the next cycle.
REQ-039 During reset, the combinational outputs follow REQ-020..026 using the cleared state.

Structure
REQ-040 Package id_pkg holds: REG_ZERO (5'd0), default NUM_STAGES, and the entry struct {valid, rd}.
REQ-041 The module id_scoreboard_entry_match holds one compare of an entry against Rs/Rt with the use flags; it is instantiated NUM_STAGES times in a generate loop.
REQ-042 No other sub-modules are used; the entry shift register and the counter are inline.

Verification
REQ-043 Back-to-back: issue add rd=8, then next cycle an instruction with Rs=8.
  - Required: 4 stall cycles (NUM_STAGES=5, WB_BYPASS=1).
  - Required: oStallCount = 4; oIDEXFlush high in each stall cycle.
REQ-044 Zero register: issue rd=0, then a reader of r0 -> no stall; oPending = 0.
REQ-045 Freeze: Freeze=1 for 3 cycles during a stall.
  - Required: entries and oStallCount frozen; oPCWrite = 0; oIDEXFlush = 0.
  - Required: the stall resumes after Freeze drops.
REQ-046 Branch: BranchTaken=1 with no hazard -> oIFIDFlush = 1 for one cycle.
  - With a hazard on Rs -> oIFIDFlush = 0 until the hazard clears.
REQ-047 Saturation: CNT_W=3 with 9 stall cycles -> oStallCount = 7 and held.
REQ-048 Reset mid-operation: Reset with 3 valid entries pending on r5 -> next cycle oPending = 0, oStallCount = 0, and a reader of r5 does not stall.
